// File: rtl/stopwatch_lap_core_pkg.sv
// Shared types and constants for the stopwatch lap engine.
// Holds the run-state encoding, the BCD time layout and the per-digit roll-over limits.
package stopwatch_pkg;

   localparam int TIME_W = 24;
   localparam int BCD_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_e;

   localparam logic [BCD_W-1:0] CS1_MAX   = 4'd9;
   localparam logic [BCD_W-1:0] CS10_MAX  = 4'd9;
   localparam logic [BCD_W-1:0] SEC1_MAX  = 4'd9;
   localparam logic [BCD_W-1:0] SEC10_MAX = 4'd5;
   localparam logic [BCD_W-1:0] MIN1_MAX  = 4'd9;
   localparam logic [BCD_W-1:0] MIN10_MAX = 4'd5;

   typedef struct packed {
      logic [BCD_W-1:0] min10;
      logic [BCD_W-1:0] min1;
      logic [BCD_W-1:0] sec10;
      logic [BCD_W-1:0] sec1;
      logic [BCD_W-1:0] cs10;
      logic [BCD_W-1:0] cs1;
   } bcd_time_t;

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Control pulses and status/display outputs of the stopwatch lap engine.
// The button chain side is the master; the stopwatch core is the slave.
interface stopwatch_lap_core_if
   import stopwatch_pkg::*;
#(
   parameter int LAP_DEPTH = 8
) ();

   localparam int IDX_W = $clog2(LAP_DEPTH);

   logic              start_stop;
   logic              lap;
   logic              clear;
   logic              view;
   logic              next;
   logic [TIME_W-1:0] time_bcd;
   logic [TIME_W-1:0] disp_bcd;
   logic              running;
   logic              view_mode;
   logic [IDX_W-1:0]  view_idx;
   logic [IDX_W:0]    lap_count;
   logic              lap_full;
   logic              ovf;

   modport master (
      output start_stop, lap, clear, view, next,
      input  time_bcd, disp_bcd, running, view_mode, view_idx, lap_count, lap_full, ovf
   );

   modport slave (
      input  start_stop, lap, clear, view, next,
      output time_bcd, disp_bcd, running, view_mode, view_idx, lap_count, lap_full, ovf
   );

endinterface

// File: rtl/stopwatch_lap_core_digit.sv
// One BCD digit of the time cascade; wraps to zero after MAX and
// raises carry in the same cycle so the next digit advances with it.
module bcd_digit_counter
   import stopwatch_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = 4'd9
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             inc,
   input  logic             clr,
   output logic [BCD_W-1:0] digit,
   output logic             carry
);

   assign carry = inc && (digit == MAX);

   // NOTE: sequential state is updated with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset_p || clr)  digit <= '0;
      else if (carry)      digit <= '0;
      else if (inc)        digit <= digit + 4'd1;
   end

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch engine: BCD mm:ss.cc counter, circular lap memory and lap recall display.
// Define LAP_OVERWRITE_EN to let a lap on a full buffer replace the oldest entry.
module stopwatch_lap_core
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV  = 1_250_000,
   parameter int LAP_DEPTH = 8
) (
   input logic                  clk,
   input logic                  reset_p,
   stopwatch_lap_core_if.slave  bus
);

   localparam int IDX_W = $clog2(LAP_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam int PRE_W = $clog2(TICK_DIV);

   localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LAP_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'(IDLE);
   localparam logic [1:0] S_RUN   = 2'(RUN);
   localparam logic [1:0] S_PAUSE = 2'(PAUSE);

`ifdef LAP_OVERWRITE_EN
   localparam bit OVERWRITE = 1'b1;
`else
   localparam bit OVERWRITE = 1'b0;
`endif

   logic [1:0]        state;
   logic [PRE_W-1:0]  presc;
   logic [IDX_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  lap_count;
   logic [IDX_W-1:0]  view_idx;
   logic              view_mode;
   logic              ovf;
   logic [TIME_W-1:0] disp_q;
   logic [TIME_W-1:0] lap_mem [LAP_DEPTH];

   logic [BCD_W-1:0] d_cs1, d_cs10, d_sec1, d_sec10, d_min1, d_min10;
   logic             c_cs1, c_cs10, c_sec1, c_sec10, c_min1, c_min10;
   bcd_time_t        t_now;

   // Only the highest-priority pulse present in a cycle acts.
   logic do_clear, do_ss, lap_req, view_req, next_req;
   assign do_clear = bus.clear;
   assign do_ss    = bus.start_stop && !bus.clear;
   assign lap_req  = bus.lap  && !bus.clear && !bus.start_stop;
   assign view_req = bus.view && !bus.clear && !bus.start_stop && !bus.lap;
   assign next_req = bus.next && !bus.clear && !bus.start_stop && !bus.lap && !bus.view;

   logic lap_full, cnt_en, tick, lap_ok, view_ok, next_ok, idx_last;
   assign lap_full = (lap_count == DEPTH_CNT);
   assign cnt_en   = (state == S_RUN) && !bus.start_stop && !bus.clear;
   assign tick     = cnt_en && (presc == TICK_LAST);
   assign lap_ok   = lap_req && (state == S_RUN) && (!lap_full || OVERWRITE);
   assign view_ok  = view_req && (lap_count != '0);
   assign next_ok  = next_req && view_mode;
   assign idx_last = ({1'b0, view_idx} == lap_count - CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset_p || do_clear) begin
         state <= S_IDLE;
         presc <= '0;
      end else begin
         if (cnt_en) presc <= tick ? '0 : presc + PRE_W'(1);
         if (do_ss)  state <= (state == S_RUN) ? S_PAUSE : S_RUN;
      end
   end

   bcd_digit_counter #(.MAX(CS1_MAX)) u_cs1 (
      .clk(clk), .reset_p(reset_p), .inc(tick), .clr(do_clear), .digit(d_cs1), .carry(c_cs1));
   bcd_digit_counter #(.MAX(CS10_MAX)) u_cs10 (
      .clk(clk), .reset_p(reset_p), .inc(c_cs1), .clr(do_clear), .digit(d_cs10), .carry(c_cs10));
   bcd_digit_counter #(.MAX(SEC1_MAX)) u_sec1 (
      .clk(clk), .reset_p(reset_p), .inc(c_cs10), .clr(do_clear), .digit(d_sec1), .carry(c_sec1));
   bcd_digit_counter #(.MAX(SEC10_MAX)) u_sec10 (
      .clk(clk), .reset_p(reset_p), .inc(c_sec1), .clr(do_clear), .digit(d_sec10), .carry(c_sec10));
   bcd_digit_counter #(.MAX(MIN1_MAX)) u_min1 (
      .clk(clk), .reset_p(reset_p), .inc(c_sec10), .clr(do_clear), .digit(d_min1), .carry(c_min1));
   bcd_digit_counter #(.MAX(MIN10_MAX)) u_min10 (
      .clk(clk), .reset_p(reset_p), .inc(c_min1), .clr(do_clear), .digit(d_min10), .carry(c_min10));

   assign t_now = '{min10: d_min10, min1: d_min1, sec10: d_sec10,
                    sec1: d_sec1, cs10: d_cs10, cs1: d_cs1};

   always_ff @(posedge clk) begin
      if (reset_p || do_clear) ovf <= 1'b0;
      else if (c_min10)        ovf <= 1'b1;
   end

   // On overwrite view_idx is deliberately left alone, so it slides one entry newer.
   always_ff @(posedge clk) begin
      if (reset_p || do_clear) begin
         wr_ptr    <= '0;
         lap_count <= '0;
         view_mode <= 1'b0;
         view_idx  <= '0;
      end else begin
         if (lap_ok) begin
            wr_ptr <= wr_ptr + IDX_W'(1);
            if (!lap_full) lap_count <= lap_count + CNT_W'(1);
         end
         if (view_ok) begin
            view_mode <= !view_mode;
            view_idx  <= '0;
         end else if (next_ok) begin
            view_idx <= idx_last ? '0 : view_idx + IDX_W'(1);
         end
      end
   end

   // NOTE: the lap memory has no reset; lap_count gates every read, so stale entries never show.
   always_ff @(posedge clk) begin
      if (lap_ok && !reset_p) lap_mem[wr_ptr] <= t_now;
   end

   // Oldest entry sits lap_count slots behind the write pointer (modulo depth).
   logic [IDX_W-1:0] rd_ptr;
   assign rd_ptr = wr_ptr - lap_count[IDX_W-1:0] + view_idx;

   always_ff @(posedge clk) begin
      if (reset_p) disp_q <= '0;
      else         disp_q <= view_mode ? lap_mem[rd_ptr] : t_now;
   end

   assign bus.time_bcd  = t_now;
   assign bus.disp_bcd  = disp_q;
   assign bus.running   = (state == S_RUN);
   assign bus.view_mode = view_mode;
   assign bus.view_idx  = view_idx;
   assign bus.lap_count = lap_count;
   assign bus.lap_full  = lap_full;
   assign bus.ovf       = ovf;

endmodule
